// File: rtl/ann_pkg.sv
// Types and constants shared by the neural-network layer stages.
// Provides the score datatype, the argmax FSM state set and an index-width helper.
package ann_pkg;

   localparam int DATA_W = 32;

   typedef logic signed [DATA_W-1:0] data_t;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } argmax_state_e;

   // Width needed to index n items, never less than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/argmax_cmp.sv
// Combinational best-so-far update for the argmax scan.
// The candidate replaces the current best only when strictly greater (signed), so ties keep the older index.
module argmax_cmp
   import ann_pkg::*;
#(
   parameter int IDX_W = 2
) (
   input  data_t            cand_val,
   input  logic [IDX_W-1:0] cand_idx,
   input  data_t            best_val,
   input  logic [IDX_W-1:0] best_idx,
   output data_t            new_val,
   output logic [IDX_W-1:0] new_idx
);

   always_comb begin
      new_val = best_val;
      new_idx = best_idx;
      if (cand_val > best_val) begin
         new_val = cand_val;
         new_idx = cand_idx;
      end
   end

endmodule

// File: rtl/argmax_layer.sv
// Per-row argmax over a snapshot of the linear stage's COUNT x OUTPUT_SIZE score matrix.
// One element is scanned per cycle; enable/done follow the same level handshake as the linear stage.
module argmax_layer
   import ann_pkg::*;
#(
   parameter int  COUNT       = 1,
   parameter int  OUTPUT_SIZE = 4,
   localparam int IDX_W       = idx_width(OUTPUT_SIZE)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  data_t            data_in   [COUNT][OUTPUT_SIZE],
   output logic [IDX_W-1:0] class_idx [COUNT],
   output data_t            max_val   [COUNT],
   output logic             busy,
   output logic             done
);

   localparam int                ROW_W    = idx_width(COUNT);
   localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(COUNT - 1);
   localparam logic [IDX_W-1:0]  LAST_COL = IDX_W'(OUTPUT_SIZE - 1);

   argmax_state_e    state_q, state_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [IDX_W-1:0] col_q, col_d;
   data_t            buf_q [COUNT][OUTPUT_SIZE];
   data_t            buf_d [COUNT][OUTPUT_SIZE];
   data_t            best_val_q, best_val_d;
   logic [IDX_W-1:0] best_idx_q, best_idx_d;
   logic [IDX_W-1:0] class_idx_q [COUNT];
   logic [IDX_W-1:0] class_idx_d [COUNT];
   data_t            max_val_q [COUNT];
   data_t            max_val_d [COUNT];
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   data_t            cur_val;
   data_t            cmp_val;
   logic [IDX_W-1:0] cmp_idx;
   data_t            scan_val;
   logic [IDX_W-1:0] scan_idx;

   assign cur_val = buf_q[row_q][col_q];

   argmax_cmp #(
      .IDX_W (IDX_W)
   ) u_cmp (
      .cand_val (cur_val),
      .cand_idx (col_q),
      .best_val (best_val_q),
      .best_idx (best_idx_q),
      .new_val  (cmp_val),
      .new_idx  (cmp_idx)
   );

   // First column of a row seeds the best unconditionally.
   assign scan_val = (col_q == '0) ? cur_val : cmp_val;
   assign scan_idx = (col_q == '0) ? '0      : cmp_idx;

   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      col_d       = col_q;
      buf_d       = buf_q;
      best_val_d  = best_val_q;
      best_idx_d  = best_idx_q;
      class_idx_d = class_idx_q;
      max_val_d   = max_val_q;

      case (state_q)
         IDLE: begin
            if (enable) begin
               buf_d = data_in;
               for (int unsigned r = 0; r < COUNT; r++) begin
                  class_idx_d[r] = '0;
                  max_val_d[r]   = '0;
               end
               row_d   = '0;
               col_d   = '0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            best_val_d = scan_val;
            best_idx_d = scan_idx;
            if (col_q == LAST_COL) begin
               class_idx_d[row_q] = scan_idx;
               max_val_d[row_q]   = scan_val;
               col_d              = '0;
               if (row_q == LAST_ROW) begin
                  row_d   = '0;
                  state_d = DONE;
               end else begin
                  row_d = row_q + ROW_W'(1);
               end
            end else begin
               col_d = col_q + IDX_W'(1);
            end
         end
         DONE: begin
            if (!enable) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == SCAN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         row_q      <= '0;
         col_q      <= '0;
         best_val_q <= '0;
         best_idx_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         for (int unsigned r = 0; r < COUNT; r++) begin
            class_idx_q[r] <= '0;
            max_val_q[r]   <= '0;
            for (int unsigned c = 0; c < OUTPUT_SIZE; c++) begin
               buf_q[r][c] <= '0;
            end
         end
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         best_val_q  <= best_val_d;
         best_idx_q  <= best_idx_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         class_idx_q <= class_idx_d;
         max_val_q   <= max_val_d;
         buf_q       <= buf_d;
      end
   end

   assign class_idx = class_idx_q;
   assign max_val   = max_val_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_argmax_layer.sv
// Self-checking bench for argmax_layer: three parameterisations, table-driven 2x4 runs,
// randomized vectors against a max-then-first-index reference, and handshake/reset sequences.
module tb_argmax_layer;
   import ann_pkg::*;

   typedef struct packed {
      logic [1:0][3:0][31:0] d;
      logic [1:0][1:0]       idx;
      logic [1:0][31:0]      mx;
   } vec_t;

   logic clk = 1'b0;
   logic rst;

   logic       en_a, busy_a, done_a;
   data_t      din_a [2][4];
   logic [1:0] idx_a [2];
   data_t      max_a [2];

   logic       en_b, busy_b, done_b;
   data_t      din_b [1][4];
   logic [1:0] idx_b [1];
   data_t      max_b [1];

   logic       en_c, busy_c, done_c;
   data_t      din_c [3][1];
   logic [0:0] idx_c [3];
   data_t      max_c [3];

   int errors = 0;
   int checks = 0;

   vec_t tbl [10];

   always #5 clk = ~clk;

   argmax_layer #(.COUNT(2), .OUTPUT_SIZE(4)) dut_a (
      .clk(clk), .rst(rst), .enable(en_a), .data_in(din_a),
      .class_idx(idx_a), .max_val(max_a), .busy(busy_a), .done(done_a));

   argmax_layer #(.COUNT(1), .OUTPUT_SIZE(4)) dut_b (
      .clk(clk), .rst(rst), .enable(en_b), .data_in(din_b),
      .class_idx(idx_b), .max_val(max_b), .busy(busy_b), .done(done_b));

   argmax_layer #(.COUNT(3), .OUTPUT_SIZE(1)) dut_c (
      .clk(clk), .rst(rst), .enable(en_c), .data_in(din_c),
      .class_idx(idx_c), .max_val(max_c), .busy(busy_c), .done(done_c));

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference: row maximum first, then the lowest index holding that value.
   function automatic void model(input logic [3:0][31:0] row,
                                 output logic [1:0] idx, output logic [31:0] mx);
      data_t m;
      m = row[0];
      for (int c = 1; c < 4; c++) if ($signed(row[c]) > m) m = row[c];
      mx  = m;
      idx = 2'd0;
      for (int c = 3; c >= 0; c--) if (row[c] == m) idx = 2'(c);
   endfunction

   function automatic logic [31:0] rnd();
      case ($urandom_range(0, 4))
         0:       return 32'h8000_0000;
         1:       return 32'h7fff_ffff;
         2:       return 32'($urandom_range(0, 3));
         3:       return 32'(0 - $urandom_range(1, 3));
         default: return $urandom;
      endcase
   endfunction

   task automatic run_a(input vec_t v, input int hold, input string tag);
      int cyc, nbusy;
      @(negedge clk);
      for (int r = 0; r < 2; r++) for (int c = 0; c < 4; c++) din_a[r][c] = v.d[r][c];
      en_a = 1'b1;
      @(negedge clk);
      for (int r = 0; r < 2; r++) for (int c = 0; c < 4; c++) din_a[r][c] = 32'sd100;
      cyc   = 0;
      nbusy = 0;
      while (!done_a && cyc < 40) begin
         if (cyc >= hold) en_a = 1'b0;
         if (busy_a) nbusy++;
         if (cyc == 4) begin
            chk({tag, " early idx0"}, idx_a[0], v.idx[0]);
            chk({tag, " early max0"}, max_a[0], $signed(v.mx[0]));
            chk({tag, " early max1 cleared"}, max_a[1], 0);
         end
         @(negedge clk);
         cyc++;
      end
      en_a = 1'b0;
      chk({tag, " latency"}, cyc, 8);
      chk({tag, " busy cycles"}, nbusy, 8);
      chk({tag, " busy low at done"}, busy_a, 0);
      for (int r = 0; r < 2; r++) begin
         chk($sformatf("%s idx%0d", tag, r), idx_a[r], v.idx[r]);
         chk($sformatf("%s max%0d", tag, r), max_a[r], $signed(v.mx[r]));
      end
      @(negedge clk);
      chk({tag, " done pulse"}, done_a, 0);
   endtask

   initial begin
      int cyc, nbusy;
      logic [1:0]  t_idx;
      logic [31:0] t_mx;

      rst  = 1'b1;
      en_a = 1'b0;
      en_b = 1'b0;
      en_c = 1'b0;
      for (int r = 0; r < 2; r++) for (int c = 0; c < 4; c++) din_a[r][c] = '0;
      for (int c = 0; c < 4; c++) din_b[0][c] = '0;
      for (int r = 0; r < 3; r++) din_c[r][0] = '0;

      // Vector table: two hand-derived rows, then randomized rows from the reference.
      tbl[0].d[0][0] = -32'sd5; tbl[0].d[0][1] = -32'sd2; tbl[0].d[0][2] = -32'sd9; tbl[0].d[0][3] = -32'sd2;
      tbl[0].d[1][0] = 32'h8000_0000; tbl[0].d[1][1] = 32'h8000_0000; tbl[0].d[1][2] = 32'd1; tbl[0].d[1][3] = 32'd1;
      tbl[0].idx[0] = 2'd1; tbl[0].mx[0] = -32'sd2;
      tbl[0].idx[1] = 2'd2; tbl[0].mx[1] = 32'd1;
      tbl[1].d[0][0] = 32'd3; tbl[1].d[0][1] = -32'sd7; tbl[1].d[0][2] = 32'd12; tbl[1].d[0][3] = 32'd5;
      for (int c = 0; c < 4; c++) tbl[1].d[1][c] = 32'h8000_0000;
      tbl[1].idx[0] = 2'd2; tbl[1].mx[0] = 32'd12;
      tbl[1].idx[1] = 2'd0; tbl[1].mx[1] = 32'h8000_0000;
      for (int i = 2; i < 10; i++) begin
         for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) tbl[i].d[r][c] = rnd();
            model(tbl[i].d[r], t_idx, t_mx);
            tbl[i].idx[r] = t_idx;
            tbl[i].mx[r]  = t_mx;
         end
      end

      #2 rst = 1'b0;
      #2;
      chk("reset busy", busy_a, 0);
      chk("reset done", done_a, 0);
      chk("reset idx0", idx_a[0], 0);
      chk("reset max1", max_a[1], 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // 1x4: single row, pulsed enable.
      @(negedge clk);
      din_b[0][0] = 32'sd3; din_b[0][1] = -32'sd7; din_b[0][2] = 32'sd12; din_b[0][3] = 32'sd5;
      en_b = 1'b1;
      @(negedge clk);
      en_b  = 1'b0;
      cyc   = 0;
      nbusy = 0;
      while (!done_b && cyc < 40) begin
         if (busy_b) nbusy++;
         @(negedge clk);
         cyc++;
      end
      chk("b latency", cyc, 4);
      chk("b busy cycles", nbusy, 4);
      chk("b idx", idx_b[0], 2);
      chk("b max", max_b[0], 12);
      @(negedge clk);
      chk("b done pulse", done_b, 0);

      // 3x1: one-element rows.
      @(negedge clk);
      din_c[0][0] = 32'sd7; din_c[1][0] = -32'sd1; din_c[2][0] = 32'sd0;
      en_c = 1'b1;
      @(negedge clk);
      en_c = 1'b0;
      cyc  = 0;
      while (!done_c && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      chk("c latency", cyc, 3);
      for (int r = 0; r < 3; r++) chk($sformatf("c idx%0d", r), idx_c[r], 0);
      chk("c max0", max_c[0], 7);
      chk("c max1", max_c[1], -1);
      chk("c max2", max_c[2], 0);

      for (int i = 0; i < 10; i++) run_a(tbl[i], (i * 2) % 8, $sformatf("v%0d", i));

      // enable held through DONE: no restart until seen low.
      @(negedge clk);
      for (int r = 0; r < 2; r++) for (int c = 0; c < 4; c++) din_a[r][c] = tbl[1].d[r][c];
      en_a = 1'b1;
      cyc  = 0;
      while (!done_a && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      chk("hold done arrives", done_a, 1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("hold done %0d", k), done_a, 1);
         chk($sformatf("hold busy %0d", k), busy_a, 0);
         chk($sformatf("hold max0 %0d", k), max_a[0], 12);
      end
      en_a = 1'b0;
      @(negedge clk);
      chk("hold release done", done_a, 0);
      chk("hold release busy", busy_a, 0);
      run_a(tbl[2], 0, "rerun");

      // Reset two cycles into a scan.
      @(negedge clk);
      for (int r = 0; r < 2; r++) for (int c = 0; c < 4; c++) din_a[r][c] = tbl[3].d[r][c];
      en_a = 1'b1;
      @(negedge clk);
      en_a = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre-reset busy", busy_a, 1);
      #2 rst = 1'b0;
      #1;
      chk("rst busy", busy_a, 0);
      chk("rst done", done_a, 0);
      chk("rst a idx0", idx_a[0], 0);
      chk("rst a max0", max_a[0], 0);
      chk("rst b idx", idx_b[0], 0);
      chk("rst b max", max_b[0], 0);
      chk("rst c max0", max_c[0], 0);
      chk("rst c max1", max_c[1], 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("post-rst idle busy", busy_a, 0);
      chk("post-rst idle done", done_a, 0);
      run_a(tbl[4], 1, "post-rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
